vcpu_mem_resp: RTL
==================

Name: vcpu_mem_resp

Overview:
- Memory responder for the vcpu data-memory toggle handshake. The core flips `mem_req` to post a read or write; this block performs the access and flips `mem_ack` back to match.
- Owns a word-addressed local data RAM with a configurable number of wait states.
- Sits beside vcpu and serves the `c.lw`/`c.sw`/`c.lwsp`/`c.swsp` paths. It is the other end of the `mem_req`/`mem_ack` protocol.

Parameters:
- DEPTH_LOG2, 10, RAM depth is 2**DEPTH_LOG2 32-bit words.
- WAIT_CYCLES, 2, extra clock cycles inserted before the RAM access (0..15).

Ports:
- sck  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous reset, active-low.
- mem_req  in  1  request toggle. A request is pending while mem_req != mem_ack.
- mem_mode  in  1  0 = read, 1 = write.
- mem_addr  in  32  byte address (n + m from the core).
- mem_wdata  in  32  write data.
- mem_ack  out  1  acknowledge toggle.
- mem_rdata  out  32  read data.
- mem_err  out  1  error on the last completed access. Constant 0 when the optional feature is off.
- busy  out  1  a transaction is in flight.

Behaviour:
- Reset:
  - Asynchronous: rst=0 forces state IDLE, mem_ack=0, mem_rdata=0, mem_err=0, busy=0, wait counter 0.
  - RAM contents are not reset.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - Let edge E be the first rising edge at which mem_req != mem_ack is sampled.
  - At E, latch mem_mode, mem_addr and mem_wdata. Load the counter with WAIT_CYCLES and set busy=1.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise ACCESS.
- WAIT: decrement the counter each edge; move to ACCESS when the counter reaches 1.
- ACCESS:
  - RAM is enabled for one cycle. Word index = latched addr[DEPTH_LOG2+1:2].
  - Addresses beyond the RAM wrap modulo the depth.
  - Write: RAM is written at this edge.
  - Read: synchronous RAM output.
- RESP (one edge):
  - Read: mem_rdata <= RAM dout. Write: mem_rdata holds its previous value.
  - mem_ack <= ~mem_ack, busy <= 0, back to IDLE.
- Latency: mem_ack toggles at edge E + WAIT_CYCLES + 2. mem_rdata is valid on that same edge and holds until the next read completes.
- Requester rules:
  - mem_mode, mem_addr and mem_wdata must stay stable from the req toggle until the ack toggle.
  - A req toggle while busy=1 is a protocol violation. The responder ignores it and is not required to detect it.
- Back-to-back: a new pending request is detectable in the IDLE cycle immediately after RESP, so there are no dead cycles beyond the IDLE sample.
- Reset mid-operation:
  - The transaction is abandoned. A RAM write lands only if the ACCESS edge already occurred.
  - After reset release, if mem_req=1, the request counts as pending and is served.
  - The core must be reset together with this block.
- Simultaneous read and write are impossible: there is one port and one transaction at a time.

Optional Feature:
- Macro: VCPU_MEM_ERR_EN.
- Enabled: in IDLE at edge E, the latched address is checked.
  - Error cases: addr[1:0] != 0, or addr >= 4*2**DEPTH_LOG2.
  - On error: RAM is never enabled, no write occurs, and mem_rdata is unchanged. The FSM still completes with the same latency and mem_err=1.
  - mem_err updates on every completion (0 on success).
- Disabled:
  - Misaligned addresses ignore bits [1:0].
  - Out-of-range addresses wrap.
  - mem_err is tied to 0.

Decomposition:
- Shared package vcpu_pkg holds:
  - MEM_MODE_READ=0 and MEM_MODE_WRITE=1 (shared with vcpu).
  - The mem_resp_state_t enum {IDLE, WAIT, ACCESS, RESP}.
  - The 32-bit word-width constant.
- One sub-module, vcpu_mem_ram: a single-port synchronous RAM with en, we, addr, din and dout, parameterised by DEPTH_LOG2.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Write 0xDEADBEEF to 0x10: ack toggles at E+4.
  - Read 0x10: mem_rdata = 0xDEADBEEF at the ack edge, busy=0 after.
- WAIT_CYCLES=0: read of an unwritten-then-written word 0x0 returns 0x12345678 with ack at E+2. Back-to-back 4 reads of addresses 0x0, 0x4, 0x8, 0xC match the prior writes.
- Write does not disturb rdata: read 0x20 = 0xA5A5A5A5, then write 0x55 to 0x24 → mem_rdata stays 0xA5A5A5A5.
- Wrap: with DEPTH_LOG2=10, writing 0x1111 to 0x1004 and reading 0x0004 returns 0x1111 (feature off).
- VCPU_MEM_ERR_EN:
  - Read 0x13 → mem_err=1, rdata unchanged, ack still at E+WAIT_CYCLES+2.
  - Write to 0x1000 → RAM word 0 unchanged.
  - The next valid access clears mem_err.
- Reset mid-WAIT: assert rst=0 one cycle after E on a write to 0x8 → mem_ack=0, busy=0, and word 0x8 is unchanged. After release with mem_req=1, a new transaction starts.

Source files
------------

// File: rtl/vcpu_pkg.sv
// Definitions shared between vcpu and its data-memory responder: word width,
// access-mode encoding, responder FSM states and the address-legality helper.
package vcpu_pkg;

    localparam int WORD_W = 32;

    localparam logic MEM_MODE_READ  = 1'b0;
    localparam logic MEM_MODE_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } mem_resp_state_t;

    // An address is illegal when not word aligned or past the last RAM word.
    function automatic logic mem_addr_err(input logic [WORD_W-1:0] addr, input int depth_log2);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = ((addr >> (depth_log2 + 2)) != 32'd0);
        return misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/vcpu_mem_ram.sv
// Single-port synchronous data RAM of 2**DEPTH_LOG2 words; dout updates only on enabled reads.
module vcpu_mem_ram
    import vcpu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]     din,
    output logic [WORD_W-1:0]     dout
);

    logic [WORD_W-1:0] mem_r [0:(1 << DEPTH_LOG2)-1];

    // Storage is deliberately not reset so it maps onto plain block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[addr] <= din;
            end else begin
                dout <= mem_r[addr];
            end
        end
    end

endmodule

// File: rtl/vcpu_mem_resp.sv
// Toggle-handshake responder serving vcpu loads/stores from a local RAM.
// Optional address checking is enabled by defining VCPU_MEM_ERR_EN.
module vcpu_mem_resp
    import vcpu_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              sck,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_mode,
    input  logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic              busy
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    mem_resp_state_t       state_r;
    logic [3:0]            cnt_r;
    logic                  mode_r;
    logic [DEPTH_LOG2-1:0] widx_r;
    logic [WORD_W-1:0]     wdata_r;
    logic                  err_r;
    logic                  ack_r;
    logic                  busy_r;
    logic                  mem_err_r;
    logic [WORD_W-1:0]     rdata_r;

    logic                  pending_s;
    logic                  addr_err_s;
    logic                  ram_en_s;
    logic                  ram_we_s;
    logic [WORD_W-1:0]     ram_dout_s;

    assign pending_s = mem_req ^ ack_r;

`ifdef VCPU_MEM_ERR_EN
    assign addr_err_s = mem_addr_err(mem_addr, DEPTH_LOG2);
`else
    // Without checking, byte-offset bits are ignored and high bits wrap away.
    logic unused_addr_s;
    assign unused_addr_s = ^{mem_addr[WORD_W-1:DEPTH_LOG2+2], mem_addr[1:0]};
    assign addr_err_s    = 1'b0;
`endif

    // A flagged access still walks the FSM but never touches the RAM.
    assign ram_en_s = (state_r == ACCESS) & ~err_r;
    assign ram_we_s = ram_en_s & (mode_r == MEM_MODE_WRITE);

    vcpu_mem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk  (sck),
        .en   (ram_en_s),
        .we   (ram_we_s),
        .addr (widx_r),
        .din  (wdata_r),
        .dout (ram_dout_s)
    );

    // Transaction sequencer: latch at the request edge, wait, access, respond.
    always_ff @(posedge sck or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            mode_r    <= MEM_MODE_READ;
            widx_r    <= '0;
            wdata_r   <= '0;
            err_r     <= 1'b0;
            ack_r     <= 1'b0;
            busy_r    <= 1'b0;
            mem_err_r <= 1'b0;
            rdata_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pending_s) begin
                        mode_r  <= mem_mode;
                        widx_r  <= mem_addr[DEPTH_LOG2+1:2];
                        wdata_r <= mem_wdata;
                        err_r   <= addr_err_s;
                        cnt_r   <= WAIT_INIT;
                        busy_r  <= 1'b1;
                        state_r <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r <= 4'd1) begin
                        state_r <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_r <= RESP;
                end
                RESP: begin
                    if (!err_r && (mode_r == MEM_MODE_READ)) begin
                        rdata_r <= ram_dout_s;
                    end
                    mem_err_r <= err_r;
                    ack_r     <= ~ack_r;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign mem_ack   = ack_r;
    assign mem_rdata = rdata_r;
    assign mem_err   = mem_err_r;
    assign busy      = busy_r;

endmodule
